// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: datapath width, default reset PC, PC increment, and the queue entry layout {pc, inst}.
package instruction_fetch_unit_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Generic synchronous FIFO used for both the instruction queue and the in-flight PC tag queue.
// Latency: a push is visible at head one cycle later. There is no bypass from push_data to head.
// Backpressure: none internally. The owner must not push when full unless it also pops.
// Ports: clk, reset (sync, active-high), push/push_data, pop, flush (wins over push/pop),
//        head (oldest entry), count, full, empty.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && !empty;

  // Storage is not reset. Its content is only observed when count says it is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // The pointers wrap naturally because DEPTH is a power of two.
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch front end. It owns the PC, issues word fetches and buffers the returned words in order for decode.
// Latency: a response in cycle N makes inst_valid high at N+1. A redirect at N gives a request at N+1 and inst_valid at N+3 at the earliest.
// Backpressure: inst_ready stalls the queue head. Requests are credit-limited so that queued plus in-flight fetches never exceed QUEUE_DEPTH.
// Ports: clk, reset (sync, active-high); imem_req_valid/ready/addr; imem_rsp_valid/data;
//        inst_valid/ready, inst_out, inst_pc; redirect_valid/pc; fault_misalign.
// Optional feature macro FETCH_MISALIGN_CHECK_EN:
//   When defined, a misaligned redirect target sets a sticky fault and halts fetch.
//   When undefined, redirect_pc[1:0] is forced to 00.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fault_misalign
);

  localparam int            CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   credit_used;
  logic            q_full, q_empty, tag_full, tag_empty;
  logic            halted;
  logic [XLEN-1:0] target;
  logic            req_fire, rsp_keep, inst_pop;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    head, hold, shown, push_entry;

  // Live in-flight fetches have a tag. Fetches that have been squashed are only counted in drop.
  // Together these give the number of responses that are still owed.
  assign outstanding = tag_count + drop;
  assign credit_used = q_count + outstanding;

  assign imem_req_valid = !reset && !redirect_valid && !halted && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // In-order memory: pending squashed responses always come before any live response.
  assign rsp_keep   = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign push_entry = '{pc: tag_head, inst: imem_rsp_data};

  assign inst_valid = !q_empty && !halted;
  assign inst_pop   = inst_valid && inst_ready && !redirect_valid;

  // When the queue is empty, the outputs keep showing the last head that was presented.
  assign shown    = q_empty ? hold : head;
  assign inst_out = shown.inst;
  assign inst_pc  = shown.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign target         = redirect_pc;
  assign halted         = fault_q;
  assign fault_misalign = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign target         = redirect_pc & ~XLEN'(3);
  assign halted         = 1'b0;
  assign fault_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= RESET_PC;
      drop <= '0;
      hold <= '0;
    end else begin
      if (!q_empty) hold <= head;
      if (redirect_valid) begin
        pc <= target;
        // After this edge, every fetch still owed is stale. This includes any fetch that was live,
        // so drop becomes the full owed count, less the response that retires in this cycle.
        drop <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + PC_STEP;
        if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  // Credit accounting guarantees that neither queue can overflow and that live responses always have a tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_keep && q_full && !inst_pop));
      assert (!(req_fire && tag_full));
      assert (!(rsp_keep && tag_empty));
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (inst_pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // PCs of live in-flight requests, popped as their responses arrive.
  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (XLEN)
  ) u_tag_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head      (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: random memory/decode timing against a queue-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHECK = 1'b1;
`else
  localparam bit MISALIGN_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault_misalign;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault_misalign (fault_misalign)
  );

  // Memory-side view: each accepted request, when its response is due, and whether a redirect squashed it.
  typedef struct {
    logic [31:0] dut_addr;
    logic [31:0] exp_pc;
    int          due;
    bit          stale;
  } mem_req_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_t;

  mem_req_t    mem_q[$];
  inst_t       model_q[$];
  inst_t       last_shown;
  logic [31:0] exp_req_pc, next_pop_pc, last_acc_addr;
  bit          model_halted, model_fault;
  int          cyc, lat, p_ready, p_inst_ready;
  int          n_cmp, n_bad, n_acc, n_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    model_q.delete();
    exp_req_pc   = RST_PC;
    next_pop_pc  = RST_PC;
    last_shown   = '0;
    model_halted = 1'b0;
    model_fault  = 1'b0;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = $urandom();
      #1;
      check_eq("req_valid_in_reset", imem_req_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle. Check the registered outputs, drive inputs, check the request side,
  // then advance the reference model to its state after the coming posedge.
  task automatic step(input bit do_redir, input logic [31:0] tgt, input bit force_ir, input bit ir_val);
    bit       rsp, exp_rv;
    inst_t    hd;
    mem_req_t m;
    @(negedge clk);
    check_eq("inst_valid", inst_valid, (model_q.size() > 0) && !model_halted);
    hd = (model_q.size() > 0) ? model_q[0] : last_shown;
    check_eq("inst_pc", inst_pc, hd.pc);
    check_eq("inst_out", inst_out, hd.inst);
    check_eq("fault_misalign", fault_misalign, model_fault);
    if (model_q.size() > 0) last_shown = model_q[0];

    rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0].dut_addr) : $urandom();
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    inst_ready     = force_ir ? ir_val : ($urandom_range(0, 99) < p_inst_ready);
    redirect_valid = do_redir;
    redirect_pc    = do_redir ? tgt : $urandom();
    #1;
    exp_rv = !do_redir && !model_halted && ((model_q.size() + mem_q.size()) < DEPTH);
    check_eq("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check_eq("req_addr", imem_req_addr, exp_req_pc);

    // Decode side: consecutive consumed PCs advance by 4 until a redirect restarts them at the target.
    if (inst_valid && inst_ready && !do_redir) begin
      check_eq("pc_sequence", inst_pc, next_pop_pc);
      next_pop_pc = next_pop_pc + 32'd4;
      n_pop++;
    end
    if (imem_req_valid && imem_req_ready) begin
      n_acc++;
      last_acc_addr = imem_req_addr;
    end

    if ((model_q.size() > 0) && !model_halted && inst_ready && !do_redir) void'(model_q.pop_front());
    if (rsp) begin
      m = mem_q.pop_front();
      if (!m.stale && !do_redir) model_q.push_back('{pc: m.exp_pc, inst: mem_word(m.exp_pc)});
    end
    if (exp_rv && imem_req_ready) begin
      mem_q.push_back('{dut_addr: imem_req_addr, exp_pc: exp_req_pc, due: cyc + lat, stale: 1'b0});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (do_redir) begin
      model_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      if (MISALIGN_CHECK && (tgt[1:0] != 2'b00)) begin
        model_halted = 1'b1;
        model_fault  = 1'b1;
      end
      exp_req_pc  = tgt & ~32'h3;
      next_pop_pc = tgt & ~32'h3;
    end
    cyc++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    int          budget;
    n_cmp = 0; n_bad = 0; n_acc = 0; n_pop = 0; cyc = 0;
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; last_acc_addr = '0;
    model_reset();

    // Streaming from RESET_PC with a 1-cycle memory.
    lat = 1; p_ready = 100; p_inst_ready = 100;
    do_reset();
    n_pop = 0;
    repeat (12) step(1'b0, '0, 1'b0, 1'b0);
    check_eq("t1_delivered_3", n_pop >= 3, 1'b1);

    // Decode stalled: exactly DEPTH requests, then issue resumes.
    do_reset();
    n_acc = 0;
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("t2_stalled_issue", n_acc, DEPTH);
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    check_eq("t2_resumed", n_acc > DEPTH, 1'b1);

    // Two fetches in flight, redirect to 0x200, first new instruction 3 cycles later.
    do_reset();
    lat = 2;
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    lat = 1;
    step(1'b1, 32'h200, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("t3_valid_at_n3", inst_valid, 1'b1);
    check_eq("t3_pc_at_n3", inst_pc, 32'h200);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);

    // Redirect in the same cycle as a response and a pop.
    do_reset();
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h300, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("t4_no_stale_valid", inst_valid, 1'b0);
    repeat (6) step(1'b0, '0, 1'b0, 1'b0);

    // Random memory/decode timing, 3-cycle memory, occasional aligned redirects.
    do_reset();
    lat = 3; p_ready = 50; p_inst_ready = 70;
    n_pop = 0; budget = 0;
    while (n_pop < 1000 && budget < 20000) begin
      t = 32'($urandom_range(0, 1023)) << 2;
      step($urandom_range(0, 99) < 2, t, 1'b0, 1'b0);
      budget++;
    end
    check_eq("t5_delivered_1000", n_pop >= 1000, 1'b1);

    // Misaligned redirect target.
    lat = 1; p_ready = 100; p_inst_ready = 100;
    do_reset();
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h202, 1'b0, 1'b0);
    n_acc = 0;
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    if (MISALIGN_CHECK) begin
      check_eq("t6_fault_set", fault_misalign, 1'b1);
      check_eq("t6_halt_no_req", imem_req_valid, 1'b0);
      check_eq("t6_no_issue", n_acc, 0);
    end else begin
      check_eq("t6_fault_clear", fault_misalign, 1'b0);
      check_eq("t6_issued", n_acc > 0, 1'b1);
      check_eq("t6_aligned_addr", last_acc_addr, 32'h200 + 32'(4 * (n_acc - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
